// File: rtl/mt_bounded_sampler.sv
// mt_bounded_sampler
//   Consumes raw 32-bit words from the Mersenne-twister generator into a small
//   prefetch FIFO. Serves bounded-integer requests with uniform results in
//   [0, bound) by power-of-two mask rejection sampling.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   mt_ready, mt_rnum     generator word valid / generator word
//   mt_trig               consume current generator word (push into FIFO)
//   req_valid, req_bound  request handshake in; bound 0 = full 32-bit range
//   req_ready             high only while idle
//   out_valid, out_data   result stream, held until out_ready
//   out_ready             result consumed
//   reject_cnt            rejections for current/last request, saturating
module mt_bounded_sampler #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TRIG_GAP   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mt_ready,
  input  logic [31:0] mt_rnum,
  output logic        mt_trig,
  input  logic        req_valid,
  input  logic [31:0] req_bound,
  output logic        req_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic [15:0] reject_cnt
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned GW = (TRIG_GAP > 0) ? $clog2(TRIG_GAP + 1) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'(TRIG_GAP);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DRAW, S_OUT} state_t;

  // ---------------------------------------------------------------- fetch side
  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          push, pop;

  // No credit is taken for a pop in the same cycle: a full FIFO never triggers.
  assign push    = mt_ready && (gap_q == '0) && (count_q < DEPTH_C);
  assign mt_trig = push;

  always_comb begin
    gap_d = gap_q;
    if (!mt_ready || push) begin
      gap_d = GAP_LOAD;
    end else if (gap_q != '0) begin
      gap_d = gap_q - GW'(1);
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      gap_q    <= GAP_LOAD;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
      gap_q   <= gap_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= mt_rnum;
  end

  // ------------------------------------------------------------- sampler FSM
  state_t        state_q, state_d;
  logic [31:0]   bound_q, mask_q, out_q, mask_calc;
  logic [15:0]   rej_q;
  logic [31:0]   head, cand;
  logic          fifo_empty, accept;

  assign head       = mem_q[rd_ptr_q];
  assign fifo_empty = (count_q == '0);
  assign cand       = head & mask_q;
  assign accept     = (bound_q == '0) || (cand < bound_q);
  assign pop        = (state_q == S_DRAW) && !fifo_empty;

  // Smear bound-1 rightwards to get the smallest 2^k-1 >= bound-1.
  // bound 0 wraps to all ones, which is the full-range mask.
  always_comb begin
    mask_calc = bound_q - 32'd1;
    mask_calc = mask_calc | (mask_calc >> 1);
    mask_calc = mask_calc | (mask_calc >> 2);
    mask_calc = mask_calc | (mask_calc >> 4);
    mask_calc = mask_calc | (mask_calc >> 8);
    mask_calc = mask_calc | (mask_calc >> 16);
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_valid)     state_d = S_CALC;
      S_CALC:                     state_d = S_DRAW;
      S_DRAW:  if (pop && accept) state_d = S_OUT;
      S_OUT:   if (out_ready)     state_d = S_IDLE;
      default:                    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == S_IDLE);
    out_valid = (state_q == S_OUT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bound_q <= '0;
      mask_q  <= '0;
      out_q   <= '0;
      rej_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (req_valid) begin
          bound_q <= req_bound;
          rej_q   <= '0;
        end
        S_CALC: mask_q <= mask_calc;
        S_DRAW: if (pop) begin
          if (accept)           out_q <= cand;
          else if (rej_q != '1) rej_q <= rej_q + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign out_data   = out_q;
  assign reject_cnt = rej_q;

endmodule

// File: tb/tb_mt_bounded_sampler.sv
module tb_mt_bounded_sampler;

  logic        clk = 1'b0;
  logic        rst;
  logic        mt_ready;
  logic [31:0] mt_rnum;
  logic        mt_trig;
  logic        req_valid;
  logic [31:0] req_bound;
  logic        req_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic [15:0] reject_cnt;

  always #5 clk = ~clk;

  mt_bounded_sampler #(.FIFO_DEPTH(4), .TRIG_GAP(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .mt_ready   (mt_ready),
    .mt_rnum    (mt_rnum),
    .mt_trig    (mt_trig),
    .req_valid  (req_valid),
    .req_bound  (req_bound),
    .req_ready  (req_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .reject_cnt (reject_cnt)
  );

  // Generator stand-in: presents gen_words[gen_idx], advances on mt_trig.
  logic [31:0] gen_words [256];
  logic [7:0]  gen_idx = 8'd0;
  logic        gen_clr = 1'b0;

  always @(posedge clk) begin
    if (gen_clr)      gen_idx <= 8'd0;
    else if (mt_trig) gen_idx <= gen_idx + 8'd1;
  end
  assign mt_rnum = gen_words[gen_idx];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut(input logic rdy);
    rst       = 1'b1;
    gen_clr   = 1'b1;
    mt_ready  = rdy;
    req_valid = 1'b0;
    req_bound = '0;
    out_ready = 1'b0;
    step;
    rst     = 1'b0;
    gen_clr = 1'b0;
  endtask

  // Waits (bounded) for out_valid; returns cycles elapsed since the accept edge.
  task automatic wait_out(output int lat);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      step;
      lat++;
    end
  endtask

  typedef struct {
    logic [31:0] bound;
    logic [31:0] w0, w1, w2;
    logic [31:0] exp_data;
    logic [15:0] exp_rej;
    int          exp_lat;
  } vec_t;

  vec_t vecs [10];

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    for (int i = 0; i < 256; i++) gen_words[i] = 32'h0;
    gen_words[0] = v.w0;
    gen_words[1] = v.w1;
    gen_words[2] = v.w2;
    reset_dut(1'b1);
    check($sformatf("vec%0d reset out_data", idx), out_data, 32'h0);
    check($sformatf("vec%0d reset reject_cnt", idx), {16'h0, reject_cnt}, 32'h0);
    repeat (12) step;
    mt_ready  = 1'b0;
    req_valid = 1'b1;
    req_bound = v.bound;
    step;
    req_valid = 1'b0;
    wait_out(lat);
    check($sformatf("vec%0d latency", idx), lat, v.exp_lat);
    check($sformatf("vec%0d out_data", idx), out_data, v.exp_data);
    check($sformatf("vec%0d reject_cnt", idx), {16'h0, reject_cnt}, {16'h0, v.exp_rej});
    check($sformatf("vec%0d req_ready in OUT", idx), {31'h0, req_ready}, 32'h0);
    out_ready = 1'b1;
    step;
    out_ready = 1'b0;
    check($sformatf("vec%0d req_ready after handshake", idx), {31'h0, req_ready}, 32'h1);
    check($sformatf("vec%0d out_valid after handshake", idx), {31'h0, out_valid}, 32'h0);
  endtask

  initial begin
    int lat;
    int trigs;
    int k;

    //            bound          w0            w1            w2            data          rej  lat
    vecs[0] = '{32'd10,       32'h0000000F, 32'h0000000C, 32'h00000007, 32'h00000007, 16'd2, 5};
    vecs[1] = '{32'd0,        32'hDEADBEEF, 32'h0,        32'h0,        32'hDEADBEEF, 16'd0, 3};
    vecs[2] = '{32'd1,        32'hFFFFFFFF, 32'h0,        32'h0,        32'h00000000, 16'd0, 3};
    vecs[3] = '{32'h80000001, 32'h90000000, 32'h12345678, 32'h0,        32'h12345678, 16'd1, 4};
    vecs[4] = '{32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h0,        32'h7FFFFFFF, 16'd0, 3};
    vecs[5] = '{32'd6,        32'h00000007, 32'h0000000E, 32'h00000005, 32'h00000005, 16'd2, 5};
    vecs[6] = '{32'd2,        32'hABCDEF03, 32'h0,        32'h0,        32'h00000001, 16'd0, 3};
    vecs[7] = '{32'd3,        32'h00000007, 32'h00000002, 32'h0,        32'h00000002, 16'd1, 4};
    vecs[8] = '{32'd16,       32'h1234567F, 32'h0,        32'h0,        32'h0000000F, 16'd0, 3};
    vecs[9] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h0,        32'hFFFFFFFE, 16'd1, 4};

    for (int i = 0; i < 256; i++) gen_words[i] = 32'h0;

    // Reset values and fetch cadence with mt_ready held high.
    reset_dut(1'b1);
    check("reset req_ready", {31'h0, req_ready}, 32'h1);
    check("reset out_valid", {31'h0, out_valid}, 32'h0);
    check("reset out_data", out_data, 32'h0);
    check("reset reject_cnt", {16'h0, reject_cnt}, 32'h0);
    for (int c = 0; c < 16; c++) begin
      check($sformatf("trig cadence c%0d", c), {31'h0, mt_trig},
            (c == 2 || c == 5 || c == 8 || c == 11) ? 32'h1 : 32'h0);
      step;
    end

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // bound=8 over 100 random words: never rejects, result is word & 7.
    for (int i = 0; i < 256; i++) gen_words[i] = $urandom;
    reset_dut(1'b1);
    for (int i = 0; i < 100; i++) begin
      req_valid = 1'b1;
      req_bound = 32'd8;
      k = 0;
      while (req_ready !== 1'b1 && k < 20) begin
        step;
        k++;
      end
      step;
      req_valid = 1'b0;
      wait_out(lat);
      check($sformatf("rand%0d out_data", i), out_data, gen_words[i] & 32'h7);
      check($sformatf("rand%0d reject_cnt", i), {16'h0, reject_cnt}, 32'h0);
      out_ready = 1'b1;
      step;
      out_ready = 1'b0;
    end

    // Result held for 10 cycles while the FIFO refills.
    for (int i = 0; i < 256; i++) gen_words[i] = 32'hA5000000 + i;
    reset_dut(1'b1);
    repeat (12) step;
    req_valid = 1'b1;
    req_bound = 32'd0;
    step;
    req_valid = 1'b0;
    wait_out(lat);
    check("hold latency", lat, 3);
    trigs = 0;
    for (int h = 0; h < 10; h++) begin
      if (mt_trig === 1'b1) trigs++;
      check($sformatf("hold h%0d out_data", h), out_data, 32'hA5000000);
      check($sformatf("hold h%0d req_ready", h), {31'h0, req_ready}, 32'h0);
      if (h >= 2) check($sformatf("hold h%0d mt_trig", h), {31'h0, mt_trig}, 32'h0);
      step;
    end
    check("hold refill trig count", trigs, 1);
    out_ready = 1'b1;
    step;
    out_ready = 1'b0;
    check("hold release req_ready", {31'h0, req_ready}, 32'h1);

    // mt_ready drop at gap 0, then reset while stalled in DRAW with empty FIFO.
    for (int i = 0; i < 256; i++) gen_words[i] = 32'h7;
    reset_dut(1'b1);
    step;
    step;
    mt_ready = 1'b0;
    #1;
    check("drop ready c2 mt_trig", {31'h0, mt_trig}, 32'h0);
    step;
    mt_ready = 1'b1;
    #1;
    check("drop ready c3 mt_trig", {31'h0, mt_trig}, 32'h0);
    step;
    check("drop ready c4 mt_trig", {31'h0, mt_trig}, 32'h0);
    step;
    check("drop ready c5 mt_trig", {31'h0, mt_trig}, 32'h1);
    step;
    mt_ready  = 1'b0;
    req_valid = 1'b1;
    req_bound = 32'd5;
    step;
    req_valid = 1'b0;
    step;
    step;
    check("stall reject_cnt", {16'h0, reject_cnt}, 32'h1);
    check("stall out_valid", {31'h0, out_valid}, 32'h0);
    check("stall req_ready", {31'h0, req_ready}, 32'h0);
    step;
    check("stall still waiting", {31'h0, out_valid}, 32'h0);
    reset_dut(1'b1);
    check("rst in DRAW req_ready", {31'h0, req_ready}, 32'h1);
    check("rst in DRAW out_valid", {31'h0, out_valid}, 32'h0);
    check("rst in DRAW reject_cnt", {16'h0, reject_cnt}, 32'h0);
    check("rst in DRAW trig c0", {31'h0, mt_trig}, 32'h0);
    step;
    check("rst in DRAW trig c1", {31'h0, mt_trig}, 32'h0);
    step;
    check("rst in DRAW trig c2", {31'h0, mt_trig}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
